// File: rtl/shift_cmd_sequencer_pkg.sv
// Shared types and entry-layout helpers for the shift-register command sequencer.
// The FIFO entry packs {load, data, shift, mode, rpt} with rpt in the LSBs.
package shift_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } seq_state_e;

  function automatic int entry_width(input int width, input int shw, input int modew,
                                     input int cntw);
    return 1 + width + shw + modew + cntw;
  endfunction

  function automatic int mode_lsb(input int cntw);
    return cntw;
  endfunction

  function automatic int shift_lsb(input int modew, input int cntw);
    return cntw + modew;
  endfunction

  function automatic int data_lsb(input int shw, input int modew, input int cntw);
    return cntw + modew + shw;
  endfunction

endpackage

// File: rtl/shift_cmd_sequencer_cmd_fifo.sv
// Synchronous show-ahead command FIFO; pointers carry one extra wrap bit so
// full and empty fall out of a single pointer compare.
module cmd_fifo #(
  parameter int EW    = 28,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [EW-1:0] wr_data,
  input  logic          rd_en,
  output logic [EW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset: contents are only visible once a write has made them valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command front-end for the universal shift register: queues commands, runs each as an
// optional load plus R shift steps, then returns the register value on a result port.
module shift_cmd_sequencer
  import shift_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int MODEW = 3,
  parameter int CNTW  = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [SHW-1:0]   cmd_shift,
  input  logic [MODEW-1:0] cmd_mode,
  input  logic [CNTW-1:0]  cmd_rpt,
  output logic             sr_load,
  output logic [WIDTH-1:0] sr_data_in,
  output logic [SHW-1:0]   sr_shift,
  output logic [MODEW-1:0] sr_mode,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  // state    | meaning
  // IDLE     | waiting for a queued command; pops when the FIFO is not empty
  // LOAD     | one cycle driving sr_load with the command data
  // SHIFT    | R cycles driving the command shift/mode; cnt counts down to 1
  // CAPT     | register holds; res_data captured at the end of the cycle
  // RESP     | result held until res_ready

  localparam int EW        = entry_width(WIDTH, SHW, MODEW, CNTW);
  localparam int MODE_LSB  = mode_lsb(CNTW);
  localparam int SHIFT_LSB = shift_lsb(MODEW, CNTW);
  localparam int DATA_LSB  = data_lsb(SHW, MODEW, CNTW);

  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  logic             h_load;
  logic [WIDTH-1:0] h_data;
  logic [SHW-1:0]   h_shift;
  logic [MODEW-1:0] h_mode;
  logic [CNTW-1:0]  h_rpt;

  seq_state_e       state;
  logic [SHW-1:0]   w_shift;
  logic [MODEW-1:0] w_mode;
  logic [CNTW-1:0]  cnt;

  assign push_entry = {cmd_load, cmd_data, cmd_shift, cmd_mode, cmd_rpt};

  assign h_load  = fifo_head[EW-1];
  assign h_data  = fifo_head[DATA_LSB +: WIDTH];
  assign h_shift = fifo_head[SHIFT_LSB +: SHW];
  assign h_mode  = fifo_head[MODE_LSB +: MODEW];
  assign h_rpt   = fifo_head[0 +: CNTW];

  // Held low during reset so no command is accepted into a FIFO that is being flushed.
  assign cmd_ready = ~fifo_full & ~rst;
  assign pop       = (state == ST_IDLE) & ~fifo_empty;

  cmd_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cmd_valid & cmd_ready),
    .wr_data (push_entry),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Register-side outputs are set on entry to a state, so they track the state register
  // exactly; every state other than LOAD/SHIFT leaves them at zero (shift-by-0 holds).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      w_shift    <= '0;
      w_mode     <= '0;
      cnt        <= '0;
      sr_load    <= 1'b0;
      sr_data_in <= '0;
      sr_shift   <= '0;
      sr_mode    <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            w_shift <= h_shift;
            w_mode  <= h_mode;
            cnt     <= h_rpt;
            busy    <= 1'b1;
            if (h_load) begin
              state      <= ST_LOAD;
              sr_load    <= 1'b1;
              sr_data_in <= h_data;
            end else if (h_rpt != '0) begin
              state    <= ST_SHIFT;
              sr_shift <= h_shift;
              sr_mode  <= h_mode;
            end else begin
              state <= ST_CAPT;
            end
          end
        end
        ST_LOAD: begin
          sr_load    <= 1'b0;
          sr_data_in <= '0;
          if (cnt != '0) begin
            state    <= ST_SHIFT;
            sr_shift <= w_shift;
            sr_mode  <= w_mode;
          end else begin
            state <= ST_CAPT;
          end
        end
        ST_SHIFT: begin
          if (cnt != '0) cnt <= cnt - CNTW'(1);
          if (cnt <= CNTW'(1)) begin
            state    <= ST_CAPT;
            sr_shift <= '0;
            sr_mode  <= '0;
          end
        end
        ST_CAPT: begin
          res_data  <= sr_data_out;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          sr_load    <= 1'b0;
          sr_data_in <= '0;
          sr_shift   <= '0;
          sr_mode    <= '0;
          res_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Scoreboard bench for shift_cmd_sequencer with a behavioural shift-register stub.
module tb_shift_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_load = 1'b0;
  logic [15:0] cmd_data = '0;
  logic [3:0]  cmd_shift = '0;
  logic [2:0]  cmd_mode = '0;
  logic [3:0]  cmd_rpt = '0;
  logic        sr_load;
  logic [15:0] sr_data_in;
  logic [3:0]  sr_shift;
  logic [2:0]  sr_mode;
  logic [15:0] sr_data_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        busy;

  always #5 clk = ~clk;

  shift_cmd_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_data    (cmd_data),
    .cmd_shift   (cmd_shift),
    .cmd_mode    (cmd_mode),
    .cmd_rpt     (cmd_rpt),
    .sr_load     (sr_load),
    .sr_data_in  (sr_data_in),
    .sr_shift    (sr_shift),
    .sr_mode     (sr_mode),
    .sr_data_out (sr_data_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy)
  );

  // mode 0 rotl, 1 rotr, 2 shl, 3 shr, 4 asr, others hold
  function automatic logic [15:0] step(input logic [15:0] v, input logic [2:0] m,
                                       input logic [3:0] s);
    logic [31:0] d;
    d = {v, v};
    case (m)
      3'd0:    step = 16'((d << s) >> 16);
      3'd1:    step = 16'(d >> s);
      3'd2:    step = v << s;
      3'd3:    step = v >> s;
      3'd4:    step = 16'($signed(v) >>> s);
      default: step = v;
    endcase
  endfunction

  logic [15:0] sr_q = '0;
  always @(posedge clk) sr_q <= sr_load ? sr_data_in : step(sr_q, sr_mode, sr_shift);
  assign sr_data_out = sr_q;

  function automatic logic [15:0] ref_result(input logic [15:0] cur, input logic ld,
                                             input logic [15:0] dat, input logic [3:0] sh,
                                             input logic [2:0] md, input int rpt);
    logic [15:0] v;
    v = ld ? dat : cur;
    for (int i = 0; i < rpt; i++) v = step(v, md, sh);
    return v;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] model_reg = '0;

  // per-command recorder
  int          cyc = 0;
  int          load_cnt = 0, shift_cnt = 0, busy_rise = -1, rv_rise = -1;
  logic [15:0] last_load_data = '0;
  logic        prev_busy = 1'b0, prev_rv = 1'b0;
  logic        chk_sh = 1'b0;
  logic [3:0]  exp_sh = '0;
  logic [2:0]  exp_md = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sr_load) begin
      load_cnt++;
      last_load_data = sr_data_in;
      check("load_no_shift", {28'd0, sr_shift}, 32'd0);
    end
    if (sr_shift != '0) begin
      shift_cnt++;
      if (chk_sh) begin
        check("shift_amt", {28'd0, sr_shift}, {28'd0, exp_sh});
        check("shift_mode", {29'd0, sr_mode}, {29'd0, exp_md});
      end
    end
    if (busy && !prev_busy) busy_rise = cyc;
    if (res_valid && !prev_rv) rv_rise = cyc;
    prev_busy = busy;
    prev_rv   = res_valid;
  end

  task automatic clr_rec();
    load_cnt  = 0;
    shift_cnt = 0;
    busy_rise = -1;
    rv_rise   = -1;
  endtask

  // monitor: result ordering and hold stability
  logic        hold_p = 1'b0;
  logic [15:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        check("res_valid_held", {31'd0, res_valid}, 32'd1);
        check("res_data_held", {16'd0, res_data}, {16'd0, held});
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h expected none", res_data);
        end else begin
          check("res_data", {16'd0, res_data}, {16'd0, exp_q.pop_front()});
        end
      end
      hold_p = res_valid && !res_ready;
      held   = res_data;
    end
  end

  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic push_cmd(input logic ld, input logic [15:0] dat, input logic [3:0] sh,
                          input logic [2:0] md, input logic [3:0] rp);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_data  = dat;
    cmd_shift = sh;
    cmd_mode  = md;
    cmd_rpt   = rp;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: cmd_ready=0 expected 1");
    end else begin
      model_reg = ref_result(model_reg, ld, dat, sh, md, int'(rp));
      exp_q.push_back(model_reg);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: pending=%0d busy=%0b expected 0 0", exp_q.size(), busy);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // 1) reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sr", {8'd0, sr_load, sr_shift, sr_mode, sr_data_in}, 32'd0);
    check("rst_res", {14'd0, res_valid, busy, res_data}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // 2) load + 2 shifts
    res_ready = 1'b1;
    clr_rec();
    chk_sh = 1'b1; exp_sh = 4'd4; exp_md = 3'd1;
    push_cmd(1'b1, 16'h00F0, 4'd4, 3'd1, 4'd2);
    wait_done();
    chk_sh = 1'b0;
    check("t2_load_cnt", load_cnt, 1);
    check("t2_load_data", {16'd0, last_load_data}, 32'h00F0);
    check("t2_shift_cnt", shift_cnt, 2);
    check("t2_latency", rv_rise - busy_rise, 4);

    // 3) read-only
    clr_rec();
    push_cmd(1'b0, 16'h0000, 4'd0, 3'd0, 4'd0);
    wait_done();
    check("t3_load_cnt", load_cnt, 0);
    check("t3_shift_cnt", shift_cnt, 0);
    check("t3_latency", rv_rise - busy_rise, 1);

    // 4) fill FIFO with result blocked
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(1'b1, 16'($urandom), 4'($urandom_range(1, 15)), 3'($urandom_range(0, 4)),
               4'($urandom_range(0, 3)));
    repeat (12) @(negedge clk);
    check("t4_full_ready", {31'd0, cmd_ready}, 32'd0);
    check("t4_res_waiting", {31'd0, res_valid}, 32'd1);
    res_ready = 1'b1;
    wait_done();
    check("t4_ready_again", {31'd0, cmd_ready}, 32'd1);

    // 5) max repeat count
    clr_rec();
    chk_sh = 1'b1; exp_sh = 4'd1; exp_md = 3'd0;
    push_cmd(1'b0, 16'h0000, 4'd1, 3'd0, 4'd15);
    wait_done();
    chk_sh = 1'b0;
    check("t5_shift_cnt", shift_cnt, 15);
    check("t5_load_cnt", load_cnt, 0);
    check("t5_latency", rv_rise - busy_rise, 16);

    // randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++)
      push_cmd(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    wait_done();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 res_ready = 1'b1;

    // 6) reset mid-SHIFT
    push_cmd(1'b1, 16'hA5C3, 4'd3, 3'd0, 4'd10);
    push_cmd(1'b1, 16'h1234, 4'd0, 3'd0, 4'd1);
    n = 0;
    while (sr_shift == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_shift", {31'd0, (sr_shift != '0)}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_sr", {8'd0, sr_load, sr_shift, sr_mode, sr_data_in}, 32'd0);
    check("t6_rst_res", {14'd0, res_valid, busy, res_data}, 32'd0);
    check("t6_rst_ready", {31'd0, cmd_ready}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    clr_rec();
    repeat (10) @(negedge clk);
    check("t6_no_result", rv_rise, -1);
    check("t6_fifo_flushed", busy_rise, -1);
    check("t6_ready", {31'd0, cmd_ready}, 32'd1);
    push_cmd(1'b1, 16'h5A5A, 4'd2, 3'd2, 4'd3);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
